// File: rtl/spi_reg_sequencer.sv
// SPI-to-register-bus transaction sequencer.
// Each SS frame opens with a command byte (bit7 = read, low bits = start address).
// After that, every byte is either write data or a dummy that clocks out prefetched
// read data. The address auto-increments after each access. A req/ack handshake,
// bounded by a timeout, paces the register bus.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame; waiting for slave-select to rise
// CMD     | frame open; waiting for the command byte
// WDATA   | write frame; waiting for the next data byte
// WR_BUS  | write strobe held; waiting for ack or timeout
// RD_BUS  | read strobe raised (one cycle after entry) and held until ack/timeout
// RD_WAIT | read byte loaded into tx; waiting for the dummy byte to finish
module spi_reg_sequencer #(
   parameter int unsigned ADDR_W    = 7,
   parameter logic [7:0]  IDLE_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              sysClk,
   input  logic              usrReset,
   input  logic              ss_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic [7:0]        tx_data,
   output logic              tx_load,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic [7:0]        bus_rdata,
   input  logic              bus_ack,
   output logic              busy,
   output logic              err
);

   localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WDATA   = 3'd2,
      WR_BUS  = 3'd3,
      RD_BUS  = 3'd4,
      RD_WAIT = 3'd5
   } stateT;

   stateT             state, stateNext;
   logic              ssPrev;
   logic              abortPend, abortNext;
   logic [TMR_W-1:0]  timer, timerNext;
   logic [7:0]        txDataNext;
   logic              txLoadNext;
   logic [ADDR_W-1:0] busAddrNext;
   logic [7:0]        busWdataNext;
   logic              busWeNext, busReNext;
   logic              errNext;

   logic ssRise, strobeOn, ackSeen, timedOut, leaveFrame;

   assign ssRise     = ss_active & ~ssPrev;
   assign strobeOn   = bus_we | bus_re;
   assign ackSeen    = strobeOn & bus_ack;
   assign timedOut   = strobeOn & ~bus_ack & (timer == '0);
   // An abort seen in an earlier cycle suppresses the tx reload; a same-cycle drop does not.
   assign leaveFrame = abortPend | ~ss_active;
   assign busy       = (state != IDLE);

   // Next-state and next-output decode; every register's next value defaults to hold.
   always_comb begin
      stateNext    = state;
      abortNext    = abortPend;
      timerNext    = timer;
      txDataNext   = tx_data;
      txLoadNext   = 1'b0;
      busAddrNext  = bus_addr;
      busWdataNext = bus_wdata;
      busWeNext    = bus_we;
      busReNext    = bus_re;
      errNext      = err;

      if (ssRise) errNext = 1'b0;
      if (strobeOn && !bus_ack && !timedOut) timerNext = timer - TMR_ONE;

      unique case (state)
         IDLE: begin
            abortNext = 1'b0;
            if (ssRise) begin
               txDataNext = IDLE_BYTE;
               txLoadNext = 1'b1;
               stateNext  = CMD;
            end
         end
         CMD: begin
            if (rx_valid) begin
               busAddrNext = rx_data[ADDR_W-1:0];
               if (!ss_active)      stateNext = IDLE;
               else if (rx_data[7]) stateNext = RD_BUS;
               else                 stateNext = WDATA;
            end else if (!ss_active) begin
               stateNext = IDLE;
            end
         end
         WDATA: begin
            if (rx_valid) begin
               busWdataNext = rx_data;
               busWeNext    = 1'b1;
               timerNext    = TMR_LOAD;
               abortNext    = ~ss_active;
               stateNext    = WR_BUS;
            end else if (!ss_active) begin
               stateNext = IDLE;
            end
         end
         WR_BUS: begin
            if (rx_valid) errNext = 1'b1;
            if (!ss_active) abortNext = 1'b1;
            if (ackSeen || timedOut) begin
               busWeNext   = 1'b0;
               busAddrNext = bus_addr + ADDR_ONE;
               if (timedOut) errNext = 1'b1;
               stateNext = leaveFrame ? IDLE : WDATA;
            end
         end
         RD_BUS: begin
            if (rx_valid) errNext = 1'b1;
            if (!ss_active) abortNext = 1'b1;
            if (!bus_re) begin
               busReNext = 1'b1;
               timerNext = TMR_LOAD;
            end else if (ackSeen || timedOut) begin
               busReNext   = 1'b0;
               busAddrNext = bus_addr + ADDR_ONE;
               if (timedOut) errNext = 1'b1;
               if (!abortPend) begin
                  txDataNext = timedOut ? 8'hFF : bus_rdata;
                  txLoadNext = 1'b1;
               end
               stateNext = leaveFrame ? IDLE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (!ss_active)    stateNext = IDLE;
            else if (rx_valid) stateNext = RD_BUS;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State and output registers. ssPrev resets high so a select already held
   // through reset does not count as a new frame.
   always_ff @(posedge sysClk) begin
      if (usrReset) begin
         state     <= IDLE;
         ssPrev    <= 1'b1;
         abortPend <= 1'b0;
         timer     <= '0;
         tx_data   <= IDLE_BYTE;
         tx_load   <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         bus_re    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= stateNext;
         ssPrev    <= ss_active;
         abortPend <= abortNext;
         timer     <= timerNext;
         tx_data   <= txDataNext;
         tx_load   <= txLoadNext;
         bus_addr  <= busAddrNext;
         bus_wdata <= busWdataNext;
         bus_we    <= busWeNext;
         bus_re    <= busReNext;
         err       <= errNext;
      end
   end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: write/read bursts, wrap, overrun,
// timeout, abort paths and reset mid-access.
module tb_spi_reg_sequencer;

   logic       sysClk;
   logic       usrReset;
   logic       ss_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [6:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic       bus_ack;
   logic       busy;
   logic       err;

   int errors = 0;
   int checks = 0;

   int ackDelay = 2;
   int strobeAge = 0;
   bit ackGiven = 0;
   int badStrobe = 0;
   logic [7:0]  rdMem [0:127];
   logic [14:0] weQ[$];
   logic [6:0]  reAddrQ[$];
   logic [7:0]  txLog[$];

   spi_reg_sequencer #(.ADDR_W(7), .IDLE_BYTE(8'hA5), .TIMEOUT(255)) dut (
      .sysClk(sysClk), .usrReset(usrReset), .ss_active(ss_active),
      .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .err(err)
   );

   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   // Register-bus responder and output monitor; runs 1 time unit after each edge.
   initial begin
      bus_ack = 1'b0;
      bus_rdata = 8'h00;
      for (int i = 0; i < 128; i++) rdMem[i] = 8'(i + 64);
      rdMem[3] = 8'h3C;
      rdMem[4] = 8'h4D;
      forever begin
         @(posedge sysClk); #1;
         bus_ack = 1'b0;
         if (bus_we && bus_re) badStrobe++;
         if ((bus_we || bus_re) && !busy) badStrobe++;
         if (tx_load) txLog.push_back(tx_data);
         if (bus_we || bus_re) begin
            strobeAge++;
            if (strobeAge == 1) begin
               if (bus_re) reAddrQ.push_back(bus_addr);
               else        weQ.push_back({bus_addr, bus_wdata});
            end
            if (!ackGiven && ackDelay > 0 && strobeAge == ackDelay) begin
               bus_ack = 1'b1;
               bus_rdata = rdMem[bus_addr];
               ackGiven = 1'b1;
            end
         end else begin
            strobeAge = 0;
            ackGiven = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge sysClk); #2;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic clearLogs();
      weQ.delete();
      reAddrQ.delete();
      txLog.delete();
   endtask

   task automatic waitWeLow(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!bus_we) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic waitReHigh(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus_re) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic waitTx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (txLog.size() >= n) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic endFrame();
      ss_active = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      usrReset = 1'b1; ss_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      tick(); tick();
      usrReset = 1'b0;
      checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL reset_tx_data got=%h exp=a5", tx_data); end
      checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
      checks++; if (bus_addr !== 7'd0) begin errors++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
      checks++; if (bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); end
      checks++; if (bus_we !== 1'b0 || bus_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", bus_we, bus_re); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); end
      // rx_valid is ignored in IDLE
      sendByte(8'h83);
      tick();
      checks++; if (busy !== 1'b0 || bus_re !== 1'b0) begin errors++; $display("FAIL idle_ignores_rx busy=%b re=%b exp=0,0", busy, bus_re); end
   endtask

   task automatic test_write_burst();
      bit ok;
      ackDelay = 2; clearLogs();
      ss_active = 1'b1; tick();
      checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL wr_frame_load got=%b/%h exp=1/a5", tx_load, tx_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
      sendByte(8'h05); tick();
      sendByte(8'h11);
      checks++; if (bus_we !== 1'b1 || bus_addr !== 7'd5 || bus_wdata !== 8'h11) begin errors++; $display("FAIL wr_launch got=we%b a%h d%h exp=we1 a05 d11", bus_we, bus_addr, bus_wdata); end
      waitWeLow(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_ack1_timeout bus_we still high"); end
      tick();
      sendByte(8'h22);
      waitWeLow(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_ack2_timeout bus_we still high"); end
      checks++; if (weQ.size() != 2) begin errors++; $display("FAIL wr_count got=%0d exp=2", weQ.size()); end
      else begin
         checks++; if (weQ[0] !== {7'd5, 8'h11}) begin errors++; $display("FAIL wr_first got=%h exp=%h", weQ[0], {7'd5, 8'h11}); end
         checks++; if (weQ[1] !== {7'd6, 8'h22}) begin errors++; $display("FAIL wr_second got=%h exp=%h", weQ[1], {7'd6, 8'h22}); end
      end
      checks++; if (bus_addr !== 7'd7 || err !== 1'b0) begin errors++; $display("FAIL wr_final got=a%h e%b exp=a07 e0", bus_addr, err); end
      endFrame();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_read_burst();
      bit ok;
      ackDelay = 2;
      ss_active = 1'b1; tick();
      clearLogs();
      sendByte(8'h83);
      waitTx(1, 30, ok);
      checks++; if (!ok || txLog[0] !== 8'h3C || tx_data !== 8'h3C) begin errors++; $display("FAIL rd_first got=%h exp=3c", tx_data); end
      sendByte(8'h00);
      waitTx(2, 30, ok);
      checks++; if (!ok || txLog[1] !== 8'h4D) begin errors++; $display("FAIL rd_second got=%h exp=4d", tx_data); end
      sendByte(8'h00);
      waitTx(3, 30, ok);
      checks++; if (!ok || reAddrQ.size() != 3) begin errors++; $display("FAIL rd_strobe_count got=%0d exp=3", reAddrQ.size()); end
      else begin
         checks++; if (reAddrQ[0] !== 7'd3 || reAddrQ[1] !== 7'd4 || reAddrQ[2] !== 7'd5) begin errors++; $display("FAIL rd_addrs got=%h,%h,%h exp=03,04,05", reAddrQ[0], reAddrQ[1], reAddrQ[2]); end
         checks++; if (txLog[2] !== 8'h45) begin errors++; $display("FAIL rd_third got=%h exp=45", txLog[2]); end
      end
      endFrame();
   endtask

   task automatic test_wrap();
      bit ok;
      ackDelay = 2;
      ss_active = 1'b1; tick();
      clearLogs();
      sendByte(8'hFF);
      waitTx(1, 30, ok);
      checks++; if (!ok || tx_data !== 8'hBF || bus_addr !== 7'd0) begin errors++; $display("FAIL wrap_first got=d%h a%h exp=dbf a00", tx_data, bus_addr); end
      sendByte(8'h00);
      waitTx(2, 30, ok);
      checks++; if (!ok || reAddrQ.size() != 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", reAddrQ.size()); end
      else begin
         checks++; if (reAddrQ[0] !== 7'h7F || reAddrQ[1] !== 7'h00) begin errors++; $display("FAIL wrap_addrs got=%h,%h exp=7f,00", reAddrQ[0], reAddrQ[1]); end
         checks++; if (txLog[1] !== 8'h40) begin errors++; $display("FAIL wrap_data got=%h exp=40", txLog[1]); end
      end
      endFrame();
   endtask

   task automatic test_overrun();
      bit ok;
      ackDelay = 20;
      ss_active = 1'b1; tick();
      clearLogs();
      sendByte(8'h10);
      sendByte(8'hAA);
      repeat (9) tick();
      sendByte(8'hBB);
      checks++; if (err !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL ovr_err got=e%b we%b exp=e1 we1", err, bus_we); end
      waitWeLow(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovr_ack_timeout bus_we still high"); end
      repeat (5) tick();
      checks++; if (weQ.size() != 1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", weQ.size()); end
      else begin
         checks++; if (weQ[0] !== {7'h10, 8'hAA}) begin errors++; $display("FAIL ovr_write got=%h exp=%h", weQ[0], {7'h10, 8'hAA}); end
      end
      checks++; if (bus_addr !== 7'h11 || err !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL ovr_final got=a%h e%b we%b exp=a11 e1 we0", bus_addr, err, bus_we); end
      endFrame();
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      ackDelay = -1;
      ss_active = 1'b1; tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear_on_ss got=%b exp=0", err); end
      clearLogs();
      sendByte(8'h81);
      waitReHigh(5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_no_strobe bus_re never rose"); end
      cnt = 0;
      while (bus_re && cnt < 400) begin cnt++; tick(); end
      checks++; if (cnt != 255) begin errors++; $display("FAIL to_length got=%0d exp=255", cnt); end
      checks++; if (tx_load !== 1'b1 || tx_data !== 8'hFF) begin errors++; $display("FAIL to_tx got=%b/%h exp=1/ff", tx_load, tx_data); end
      checks++; if (err !== 1'b1 || bus_addr !== 7'd2) begin errors++; $display("FAIL to_state got=e%b a%h exp=e1 a02", err, bus_addr); end
      endFrame();
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky got=e%b b%b exp=e1 b0", err, busy); end
      ss_active = 1'b1; tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got=%b exp=0", err); end
      endFrame();
   endtask

   task automatic test_abort_write();
      bit ok;
      ackDelay = 6;
      ss_active = 1'b1; tick();
      clearLogs();
      sendByte(8'h20);
      sendByte(8'h77);
      ss_active = 1'b0;
      tick();
      checks++; if (busy !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL abort_hold got=b%b we%b exp=b1 we1", busy, bus_we); end
      waitWeLow(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_ack_timeout bus_we still high"); end
      checks++; if (busy !== 1'b0 || bus_addr !== 7'h21 || tx_load !== 1'b0) begin errors++; $display("FAIL abort_done got=b%b a%h l%b exp=b0 a21 l0", busy, bus_addr, tx_load); end
      checks++; if (weQ.size() != 1 || weQ[0] !== {7'h20, 8'h77}) begin errors++; $display("FAIL abort_write got=n%0d exp=1 write of 77 at 20", weQ.size()); end
      tick();
   endtask

   task automatic test_ack_ss_fall();
      bit ok;
      ackDelay = 3;
      ss_active = 1'b1; tick();
      sendByte(8'hB0);
      waitReHigh(5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fall_no_strobe bus_re never rose"); end
      tick(); tick();
      ss_active = 1'b0;
      tick();
      checks++; if (bus_re !== 1'b0 || tx_load !== 1'b1 || tx_data !== 8'h70) begin errors++; $display("FAIL fall_complete got=re%b l%b d%h exp=re0 l1 d70", bus_re, tx_load, tx_data); end
      checks++; if (busy !== 1'b0 || bus_addr !== 7'h31) begin errors++; $display("FAIL fall_idle got=b%b a%h exp=b0 a31", busy, bus_addr); end
      tick();
   endtask

   task automatic test_reset_midread();
      bit ok;
      ackDelay = -1;
      ss_active = 1'b1; tick();
      sendByte(8'h85);
      waitReHigh(5, ok);
      sendByte(8'hCC);
      checks++; if (!ok || err !== 1'b1 || bus_re !== 1'b1) begin errors++; $display("FAIL rst_pre got=e%b re%b exp=e1 re1", err, bus_re); end
      usrReset = 1'b1;
      tick();
      usrReset = 1'b0;
      checks++; if (bus_re !== 1'b0 || bus_we !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_ctrl got=re%b we%b b%b e%b exp=0000", bus_re, bus_we, busy, err); end
      checks++; if (bus_addr !== 7'd0 || bus_wdata !== 8'h00 || tx_data !== 8'hA5 || tx_load !== 1'b0) begin errors++; $display("FAIL rst_data got=a%h w%h d%h l%b exp=a00 w00 da5 l0", bus_addr, bus_wdata, tx_data, tx_load); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_frame got=%b exp=0", busy); end
      endFrame();
   endtask

   task automatic test_strobe_rules();
      checks++; if (badStrobe != 0) begin errors++; $display("FAIL strobe_rules violations=%0d exp=0", badStrobe); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_overrun();
      test_timeout();
      test_abort_write();
      test_ack_ss_fall();
      test_reset_midread();
      test_strobe_rules();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_reg_sequencer.md
Name: spi_reg_sequencer

Overview:
Transaction controller behind the mode-3 SPI slave byte interface. It turns the received byte stream into register-bus accesses. The first byte of each SS frame is a command byte: bit7 is R/nW and bits[6:0] are the start address. Following bytes are write data, or dummy bytes that clock out read data, with the address auto-incrementing on every access. It paces the register bus with a req/ack handshake and keeps the slave's transmit byte loaded ahead of each SPI byte slot.

Parameters:
ADDR_W, 7, register address width (1..7); taken from command byte bits[ADDR_W-1:0].
IDLE_BYTE, 8'hA5, byte loaded for shift-out during the command byte.
TIMEOUT, 255, max sysClk cycles a bus strobe waits for bus_ack (>=2).

Ports:
sysClk  in  1  system clock; everything is on its rising edge.
usrReset  in  1  synchronous, active-high reset.
ss_active  in  1  slave-select asserted, already synchronized to sysClk.
rx_valid  in  1  one-cycle pulse per complete received SPI byte.
rx_data  in  8  received byte; valid when rx_valid=1.
tx_data  out  8  byte the slave shifts out in the next byte slot.
tx_load  out  1  one-cycle pulse when tx_data changes.
bus_addr  out  ADDR_W  register address.
bus_wdata  out  8  write data.
bus_we  out  1  write strobe; held until ack or timeout.
bus_re  out  1  read strobe; held until ack or timeout.
bus_rdata  in  8  read data; valid in the bus_ack cycle.
bus_ack  in  1  one-cycle access completion.
busy  out  1  high in every state except IDLE.
err  out  1  sticky; set on overrun or timeout, cleared on reset or on an ss_active rising edge.

Behaviour:
- Reset values: tx_data=IDLE_BYTE, tx_load=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, err=0; state=IDLE. Reset takes effect even mid-access: strobes drop on the next edge.
- State IDLE: on ss_active 0->1: err<=0, tx_data<=IDLE_BYTE, tx_load pulse, go to CMD. rx_valid is ignored in IDLE.
- State CMD: on rx_valid: bus_addr<=rx_data[ADDR_W-1:0], rw<=rx_data[7]. If rw=1 go to RD_BUS, else go to WDATA.
- State WDATA: on rx_valid: bus_wdata<=rx_data, bus_we<=1, go to WR_BUS.
- State WR_BUS: hold bus_we. On bus_ack: bus_we<=0, bus_addr<=bus_addr+1, go to WDATA.
- State RD_BUS: bus_re asserts on the cycle after entry and is held. On bus_ack: bus_re<=0, tx_data<=bus_rdata, tx_load pulse, bus_addr<=bus_addr+1, go to RD_WAIT.
- State RD_WAIT: on rx_valid (dummy byte done, prefetched byte now shifting) go to RD_BUS. The content of the dummy byte is ignored.
- Latency: read strobe-to-tx_load is ack cycle +1. Write data-byte-to-bus_we is 1 cycle.
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0).
- Overrun: rx_valid while in WR_BUS or RD_BUS sets err, and the byte is dropped. The in-flight access still completes normally; tx_data is not re-pulsed for the lost slot.
- Timeout: a counter resets on strobe assertion. If it reaches TIMEOUT cycles without bus_ack: drop the strobe and set err. For a read, tx_data<=8'hFF with a tx_load pulse. The address still increments and the FSM proceeds as if acked.
- bus_ack outside WR_BUS/RD_BUS is ignored.
- ss_active 0 in CMD, WDATA or RD_WAIT: go to IDLE next cycle with no bus access.
- ss_active 0 in WR_BUS or RD_BUS: finish the handshake (ack or timeout), then go to IDLE. There is no tx_load on the abort path.
- Simultaneous bus_ack and ss_active falling: the access completes (address increments, tx_load for reads), then IDLE.
- Simultaneous rx_valid and ss_active 1->0: the byte is processed first (CMD latch or WDATA launch), then the abort rules apply.
- At most one strobe is high at any time; a strobe never asserts in IDLE.

Test Plan:
- Write burst: SS up, bytes 0x05,0x11,0x22, ack 2 cycles after each strobe -> writes (5,0x11) then (6,0x22), bus_addr=7, err=0.
- Read burst: SS up, command 0x83, rdata 0x3C at addr 3 and 0x4D at addr 4, two dummy bytes -> tx_load with tx_data 0x3C, then 0x4D; third strobe at addr 5.
- Wrap: command 0xFF (read, addr 127), ADDR_W=7 -> second read strobe at bus_addr=0.
- Overrun: write frame with ack delayed 20 cycles and the next rx_valid at cycle 10 -> err=1, only the first write is seen, delayed byte dropped.
- Timeout: read with bus_ack never asserted -> bus_re low after 255 cycles, tx_data=0xFF with tx_load, err=1; next SS rising edge clears err.
- Abort and reset: SS drops during WR_BUS -> write completes on ack, then IDLE, busy=0. usrReset during RD_BUS -> bus_re=0 and all outputs at reset values on the next edge.
